lcd_write_arbiter: RTL

Shares the single `lcd_write` SPI serializer among several word producers: the init sequencer, the picture row streamer and the character renderer. It sits between those producers and `lcd_write`, replacing the fixed two-way mux in `control`. Each producer is granted the serializer for a whole burst of 9-bit words. The arbiter issues one `en_write` per word, forwards `wr_done` back to the owner, enforces init-first ordering and guards against a hung serializer with a watchdog.

---
 rtl/lcd_pkg.sv | 13 +
 rtl/lcd_write_arbiter_rr_pick.sv | 28 ++
 rtl/lcd_write_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write path: word layout and arbiter state encoding.
package lcd_pkg;

  localparam int LCD_WORD_W = 9;
  localparam int LCD_DC_BIT = 8;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_OWNED     = 2'd1,
    ARB_WAIT_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/lcd_write_arbiter_rr_pick.sv
// Combinational round-robin selector: one-hot first eligible bit at or after start_i, wrapping.
module rr_pick #(
  parameter int W  = 2,
  parameter int PW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  elig_i,
  input  logic [PW-1:0] start_i,
  output logic [W-1:0]  win_o,
  output logic          found_o
);

  // Scan W positions starting at start_i; only the first eligible one is marked.
  always_comb begin
    int   idx;
    logic hit;
    idx     = 0;
    hit     = 1'b0;
    win_o   = '0;
    found_o = 1'b0;
    for (int k = 0; k < W; k++) begin
      idx        = (int'(start_i) + k) % W;
      hit        = elig_i[idx] & ~found_o;
      win_o[idx] = hit;
      found_o    = found_o | hit;
    end
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Burst arbiter sharing the lcd_write serializer: init sequencer first, round-robin
// among the others, one en_write per word and a watchdog against a hung serializer.
module lcd_write_arbiter
  import lcd_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                          sys_clk_50MHz,
  input  logic                          sys_rst,
  input  logic                          init_done,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [LCD_WORD_W*NUM_REQ-1:0] req_word,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [LCD_WORD_W-1:0]         data,
  output logic                          en_write,
  input  logic                          wr_done,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int IW   = $clog2(NUM_REQ);
  localparam int NR   = NUM_REQ - 1;
  localparam int PW   = (NR > 1) ? $clog2(NR) : 1;
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [NUM_REQ-1:0]     req_done_q, req_done_d;
  logic [LCD_WORD_W-1:0]  data_q, data_d;
  logic                   en_write_q, en_write_d;
  logic                   busy_q, busy_d;
  logic                   terr_q, terr_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]        wdog_q, wdog_d;

  logic [NR-1:0]          elig_hi_s;
  logic [NR-1:0]          pick_win_s;
  logic                   pick_found_s;
  logic [PW-1:0]          pick_start_s;
  logic [IW-1:0]          pick_idx_s;
  logic [IW-1:0]          rr_next_s;

  // Only the init sequencer may compete until initialisation is finished.
  assign elig_hi_s    = req[NUM_REQ-1:1] & {NR{init_done}};
  assign pick_start_s = PW'(rr_ptr_q - IW'(1));

  rr_pick #(.W(NR), .PW(PW)) u_rr_pick (
    .elig_i  (elig_hi_s),
    .start_i (pick_start_s),
    .win_o   (pick_win_s),
    .found_o (pick_found_s)
  );

  // Convert the round-robin winner back to a full requester index.
  always_comb begin
    pick_idx_s = IW'(1);
    for (int k = 0; k < NR; k++) begin
      pick_idx_s = pick_win_s[k] ? IW'(k + 1) : pick_idx_s;
    end
  end

  assign rr_next_s = (pick_idx_s == IW'(NUM_REQ - 1)) ? IW'(1) : pick_idx_s + IW'(1);

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    wdog_d     = wdog_q;
    data_d     = data_q;
    terr_d     = terr_q;
    en_write_d = 1'b0;
    req_done_d = '0;
    case (state_q)
      ARB_IDLE: begin
        if (req[0]) begin
          grant_d = NUM_REQ'(1);
          owner_d = '0;
          state_d = ARB_OWNED;
        end else if (pick_found_s) begin
          grant_d  = {pick_win_s, 1'b0};
          owner_d  = pick_idx_s;
          rr_ptr_d = rr_next_s;
          state_d  = ARB_OWNED;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_OWNED: begin
        // A valid left high across the req_done cycle is stale and must not resend.
        if (!req[owner_q]) begin
          grant_d = '0;
          state_d = ARB_IDLE;
        end else if (req_valid[owner_q] && !req_done_q[owner_q]) begin
          data_d     = req_word[int'(owner_q) * LCD_WORD_W +: LCD_WORD_W];
          en_write_d = 1'b1;
          wdog_d     = '0;
          state_d    = ARB_WAIT_DONE;
        end else begin
          state_d = ARB_OWNED;
        end
      end
      ARB_WAIT_DONE: begin
        if (wr_done) begin
          req_done_d[owner_q] = 1'b1;
          state_d             = ARB_OWNED;
        end else if (wdog_q == WD_LAST) begin
          terr_d  = 1'b1;
          grant_d = '0;
          state_d = ARB_IDLE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
    busy_d = |grant_d;
  end

  // State and registered outputs.
  always_ff @(posedge sys_clk_50MHz) begin
    if (sys_rst) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      req_done_q <= '0;
      data_q     <= 9'h000;
      en_write_q <= 1'b0;
      busy_q     <= 1'b0;
      terr_q     <= 1'b0;
      owner_q    <= '0;
      rr_ptr_q   <= IW'(1);
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      req_done_q <= req_done_d;
      data_q     <= data_d;
      en_write_q <= en_write_d;
      busy_q     <= busy_d;
      terr_q     <= terr_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      wdog_q     <= wdog_d;
    end
  end

  assign grant       = grant_q;
  assign req_done    = req_done_q;
  assign data        = data_q;
  assign en_write    = en_write_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule
